// File: rtl/sparc_win_pkg.sv
// Shared definitions for the SPARC register-window pointer control:
// window count, operation codes, trap causes and controller FSM states.
package sparc_win_pkg;

    localparam int unsigned NWIN = 4;

    typedef enum logic [2:0] {
        OP_SAVE       = 3'd0,
        OP_RESTORE    = 3'd1,
        OP_TRAP_ENTER = 3'd2,
        OP_RETT       = 3'd3,
        OP_WRCWP      = 3'd4,
        OP_WRWIM      = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        TT_NONE = 2'b00,
        TT_OVF  = 2'b01,
        TT_UNF  = 2'b10
    } trap_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/cwp_ctrl_wim_check.sv
// Combinational window-target computation: neighbour window in the requested
// direction (mod NWIN) and whether the window invalid mask marks it.
module wim_check
    import sparc_win_pkg::*;
#(
    parameter int unsigned NWIN = 4
) (
    input  logic [1:0]      cwp_i,
    input  logic [NWIN-1:0] wim_i,
    input  logic            dir_i,
    output logic [1:0]      target_o,
    output logic            invalid_o
);

    always_comb begin
        target_o  = (dir_i == DIR_UP) ? (cwp_i + 2'd1) : (cwp_i - 2'd1);
        invalid_o = wim_i[target_o];
    end

endmodule

// File: rtl/cwp_ctrl.sv
// Current-window-pointer / WIM controller with one-cycle window trap state.
// Optional saturating trap counters are enabled with CWP_TRAP_CNT_EN.
module cwp_ctrl
    import sparc_win_pkg::*;
#(
    parameter int unsigned NWIN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [3:0]      wdata,
    output logic            op_ready,
    output logic [1:0]      cwp,
    output logic [NWIN-1:0] wim,
    output logic            win_trap,
`ifdef CWP_TRAP_CNT_EN
    output logic [1:0]      trap_type,
    output logic [7:0]      ovf_cnt,
    output logic [7:0]      unf_cnt
`else
    output logic [1:0]      trap_type
`endif
);

    state_e          state_q, state_d;
    logic [1:0]      cwp_q, cwp_d;
    logic [NWIN-1:0] wim_q, wim_d;
    trap_e           cause_q, cause_d;

    logic            dir;
    logic [1:0]      tgt;
    logic            tgt_invalid;

    assign dir = ((op == OP_RESTORE) || (op == OP_RETT)) ? DIR_UP : DIR_DOWN;

    wim_check #(
        .NWIN (NWIN)
    ) u_wim_check (
        .cwp_i     (cwp_q),
        .wim_i     (wim_q),
        .dir_i     (dir),
        .target_o  (tgt),
        .invalid_o (tgt_invalid)
    );

    always_comb begin
        state_d = state_q;
        cwp_d   = cwp_q;
        wim_d   = wim_q;
        cause_d = cause_q;
        case (state_q)
            ST_TRAP: state_d = ST_IDLE;
            default: begin
                if (op_valid) begin
                    case (op)
                        OP_SAVE, OP_RESTORE, OP_RETT: begin
                            if (tgt_invalid) begin
                                state_d = ST_TRAP;
                                cause_d = (op == OP_SAVE) ? TT_OVF : TT_UNF;
                            end else begin
                                cwp_d = tgt;
                            end
                        end
                        OP_TRAP_ENTER: cwp_d = tgt;
                        OP_WRCWP:      cwp_d = wdata[1:0];
                        OP_WRWIM:      wim_d = wdata;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cwp_q   <= '0;
            wim_q   <= '0;
            cause_q <= TT_NONE;
        end else begin
            state_q <= state_d;
            cwp_q   <= cwp_d;
            wim_q   <= wim_d;
            cause_q <= cause_d;
        end
    end

    assign op_ready  = (state_q == ST_IDLE);
    assign win_trap  = (state_q == ST_TRAP);
    assign trap_type = win_trap ? cause_q : TT_NONE;
    assign cwp       = cwp_q;
    assign wim       = wim_q;

`ifdef CWP_TRAP_CNT_EN
    logic       trap_enter;
    logic [7:0] ovf_cnt_q, unf_cnt_q;

    assign trap_enter = (state_q == ST_IDLE) && (state_d == ST_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else if (trap_enter) begin
            if ((cause_d == TT_OVF) && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 8'd1;
            if ((cause_d == TT_UNF) && (unf_cnt_q != '1)) unf_cnt_q <= unf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign unf_cnt = unf_cnt_q;
`endif

endmodule

// File: tb/tb_cwp_ctrl.sv
// Self-checking bench for cwp_ctrl: directed scenarios plus random operations
// checked every cycle against an arithmetic model of the window rules.
module tb_cwp_ctrl;
    import sparc_win_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] wdata = 4'd0;
    logic       op_ready;
    logic [1:0] cwp;
    logic [3:0] wim;
    logic       win_trap;
    logic [1:0] trap_type;
`ifdef CWP_TRAP_CNT_EN
    logic [7:0] ovf_cnt, unf_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    // reference model state
    int m_cwp, m_wim, m_trap, m_tt, m_ovf, m_unf;

    always #5 clk = ~clk;

    cwp_ctrl #(.NWIN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op        (op),
        .wdata     (wdata),
        .op_ready  (op_ready),
        .cwp       (cwp),
        .wim       (wim),
        .win_trap  (win_trap),
`ifdef CWP_TRAP_CNT_EN
        .trap_type (trap_type),
        .ovf_cnt   (ovf_cnt),
        .unf_cnt   (unf_cnt)
`else
        .trap_type (trap_type)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cwp = 0; m_wim = 0; m_trap = 0; m_tt = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic raise(input int cause);
        m_trap = 1;
        m_tt = cause;
        if (cause == 1 && m_ovf < 255) m_ovf++;
        if (cause == 2 && m_unf < 255) m_unf++;
    endtask

    // one rising edge of the window rules
    task automatic model_step(input int v, input int o, input int wd);
        int n;
        if (m_trap != 0) begin
            m_trap = 0;
            m_tt = 0;
        end else if (v != 0) begin
            if (o == OP_SAVE) begin
                n = (m_cwp + 3) % 4;
                if (((m_wim >> n) & 1) != 0) raise(1); else m_cwp = n;
            end else if (o == OP_RESTORE || o == OP_RETT) begin
                n = (m_cwp + 1) % 4;
                if (((m_wim >> n) & 1) != 0) raise(2); else m_cwp = n;
            end else if (o == OP_TRAP_ENTER) begin
                m_cwp = (m_cwp + 3) % 4;
            end else if (o == OP_WRCWP) begin
                m_cwp = wd % 4;
            end else if (o == OP_WRWIM) begin
                m_wim = wd;
            end
        end
    endtask

    task automatic check_all();
        chk("cwp", 8'(cwp), 8'(m_cwp));
        chk("wim", 8'(wim), 8'(m_wim));
        chk("win_trap", 8'(win_trap), 8'(m_trap));
        chk("trap_type", 8'(trap_type), 8'(m_trap != 0 ? m_tt : 0));
        chk("op_ready", 8'(op_ready), 8'(m_trap == 0 ? 1 : 0));
`ifdef CWP_TRAP_CNT_EN
        chk("ovf_cnt", ovf_cnt, 8'(m_ovf));
        chk("unf_cnt", unf_cnt, 8'(m_unf));
`endif
    endtask

    // drive after a falling edge, update model on the rising edge, check on the next falling edge
    task automatic cycle(input int v, input int o, input int wd);
        op_valid = v[0];
        op = o[2:0];
        wdata = wd[3:0];
        @(posedge clk);
        model_step(v, o, wd);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // SAVE at cwp=0 wraps to window 3
        cycle(1, OP_WRWIM, 4'b0001);
        cycle(1, OP_SAVE, 0);
        chk("save_wrap_cwp", 8'(cwp), 8'd3);
        chk("save_wrap_notrap", 8'(win_trap), 8'd0);

        // overflow trap, then SAVE held during TRAP is not accepted
        cycle(1, OP_WRWIM, 4'b0100);
        cycle(1, OP_WRCWP, 3);
        cycle(1, OP_SAVE, 0);
        chk("ovf_trap", 8'(win_trap), 8'd1);
        chk("ovf_type", 8'(trap_type), 8'd1);
        chk("ovf_hold_cwp", 8'(cwp), 8'd3);
        chk("ovf_ready", 8'(op_ready), 8'd0);
        cycle(1, OP_SAVE, 0);
        chk("trap_one_cycle", 8'(win_trap), 8'd0);
        cycle(1, OP_SAVE, 0);
        chk("retrap", 8'(win_trap), 8'd1);
        cycle(0, 0, 0);

        // underflow trap at cwp=3, then unconditional TRAP_ENTER
        cycle(1, OP_WRWIM, 4'b0001);
        cycle(1, OP_RESTORE, 0);
        chk("unf_type", 8'(trap_type), 8'd2);
        chk("unf_hold_cwp", 8'(cwp), 8'd3);
        cycle(0, 0, 0);
        cycle(1, OP_TRAP_ENTER, 0);
        chk("trap_enter_cwp", 8'(cwp), 8'd2);
        chk("trap_enter_notrap", 8'(win_trap), 8'd0);
        cycle(1, OP_RETT, 0);
        cycle(1, 6, 4'hF);
        cycle(1, 7, 4'hF);

        // reset during TRAP
        cycle(1, OP_WRWIM, 4'b1111);
        cycle(1, OP_SAVE, 0);
        chk("pre_reset_trap", 8'(win_trap), 8'd1);
        async_reset();

        for (int i = 0; i < 500; i++) begin
            int o;
            o = $urandom_range(0, 7);
            if ($urandom_range(0, 15) == 0) o = OP_WRWIM;
            cycle(($urandom_range(0, 3) != 0) ? 1 : 0, o, $urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) async_reset();
        end

`ifdef CWP_TRAP_CNT_EN
        async_reset();
        cycle(1, OP_WRWIM, 4'b1111);
        for (int i = 0; i < 300; i++) begin
            cycle(1, OP_SAVE, 0);
            cycle(1, OP_SAVE, 0);
        end
        chk("ovf_sat", ovf_cnt, 8'd255);
        chk("unf_zero", unf_cnt, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
